stream_demux_1_4: RTL and testbench

- Registered 1:4 stream demultiplexer with valid/ready handshakes.
- It is the distribution-side counterpart of the 4:1 select path.
- Accepts one word plus a 2-bit destination select from a single upstream port.
- Holds the word in a one-entry output stage and presents it to exactly one of four downstream lanes until that lane accepts it.

---
 rtl/stream_demux_1_4_if.sv | 25 ++
 rtl/stream_demux_1_4.sv | 92 +++++++++
 tb/tb_stream_demux_1_4.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1_4_if.sv
// Handshake bundle for the 1:4 stream demux: one upstream port, four downstream lanes
// sharing a data bus, plus per-lane transfer counters.
interface stream_demux_1_4_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic                 up_valid;
  logic [W-1:0]         up_data;
  logic [1:0]           up_sel;
  logic                 up_ready;
  logic [3:0]           dn_valid;
  logic [W-1:0]         dn_data;
  logic [3:0]           dn_ready;
  logic [4*CNT_W-1:0]   dn_count;

  modport master (
    output up_valid, up_data, up_sel, dn_ready,
    input  up_ready, dn_valid, dn_data, dn_count
  );

  modport slave (
    input  up_valid, up_data, up_sel, dn_ready,
    output up_ready, dn_valid, dn_data, dn_count
  );
endinterface

// File: rtl/stream_demux_1_4.sv
// Registered 1:4 stream demux with a one-entry output stage.
// Optional per-lane transfer counters: define STREAM_DEMUX_COUNT_EN.

`ifdef STREAM_DEMUX_COUNT_EN
module stream_demux_1_4_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs,
  output logic [CNT_W-1:0] count
);
  // Free-running wrap, no saturation.
  always_ff @(posedge clk) begin
    if (rst)     count <= '0;
    else if (hs) count <= count + 1'b1;
  end
endmodule
`endif

module stream_demux_1_4 #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  stream_demux_1_4_if.slave s
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] data_q;
  logic [1:0]   sel_q;
  logic         sel_rdy;
  logic         up_hs;

  // Only the held lane's ready matters; this also gives bubble-free pass-through.
  assign sel_rdy    = s.dn_ready[sel_q];
  assign s.up_ready = !rst && (state_q == EMPTY || sel_rdy);
  assign up_hs      = s.up_valid && s.up_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (up_hs) state_d = FULL;
      FULL:    if (sel_rdy && !up_hs) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Word and select are retained after delivery; only a new upstream handshake replaces them.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (up_hs) begin
      data_q <= s.up_data;
      sel_q  <= s.up_sel;
    end
  end

  always_comb begin
    s.dn_valid = '0;
    s.dn_data  = '0;
    if (state_q == FULL) begin
      s.dn_valid[sel_q] = 1'b1;
      s.dn_data         = data_q;
    end
  end

`ifdef STREAM_DEMUX_COUNT_EN
  logic [3:0][CNT_W-1:0] cnt;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    stream_demux_1_4_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .hs    (s.dn_valid[i] && s.dn_ready[i]),
      .count (cnt[i])
    );
  end

  assign s.dn_count = cnt;
`else
  assign s.dn_count = '0;
`endif
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed cycle table, counter wrap, then random traffic
// against a buffer/queue reference model.
module tb_stream_demux_1_4;
  localparam int W     = 4;
  localparam int CNT_W = 8;
`ifdef STREAM_DEMUX_COUNT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_1_4_if #(.W(W), .CNT_W(CNT_W)) bus ();

  stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference model: one optional held word, counters as plain integers.
  bit         m_full;
  logic [3:0] m_data;
  logic [1:0] m_sel;
  int         m_cnt[4];
  logic [5:0] sb[$];

  task automatic model_reset();
    m_full = 0; m_data = '0; m_sel = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    sb.delete();
  endtask

  // One clock cycle: drive, compare against model and scoreboard, advance model.
  task automatic step(input logic r, input logic v, input logic [3:0] d, input logic [1:0] sl,
                      input logic [3:0] rdy, output logic o_ur, output logic [3:0] o_dv,
                      output logic [3:0] o_dd, output logic [31:0] o_cnt);
    logic        e_ur;
    logic [3:0]  e_dv, e_dd;
    logic [31:0] e_cnt;
    logic [5:0]  front;
    int          lane;
    bit          dn_hs, up_hs;
    @(negedge clk);
    rst = r; bus.up_valid = v; bus.up_data = d; bus.up_sel = sl; bus.dn_ready = rdy;
    #1;
    o_ur = bus.up_ready; o_dv = bus.dn_valid; o_dd = bus.dn_data; o_cnt = bus.dn_count;
    e_ur  = !r && (!m_full || rdy[m_sel]);
    e_dv  = m_full ? (4'b0001 << m_sel) : 4'b0000;
    e_dd  = m_full ? m_data : 4'h0;
    e_cnt = '0;
    if (FEAT) for (int i = 0; i < 4; i++) e_cnt[i*8 +: 8] = m_cnt[i][7:0];
    check("up_ready", o_ur, e_ur);
    check("dn_valid", o_dv, e_dv);
    check("dn_data",  o_dd, e_dd);
    check("dn_count", o_cnt, e_cnt);
    // Scoreboard on observed handshakes: delivery order and lane must match acceptance order.
    if (!r && (o_dv & rdy) != 4'b0) begin
      lane = 0;
      for (int i = 0; i < 4; i++) if (o_dv[i]) lane = i;
      if (sb.size() == 0) check("sb_spurious", {o_dv, o_dd}, 8'h00);
      else begin
        front = sb.pop_front();
        check("sb_order", {lane[1:0], o_dd}, front);
      end
    end
    if (!r && v && o_ur) sb.push_back({sl, d});
    dn_hs = m_full && rdy[m_sel];
    up_hs = v && e_ur;
    @(posedge clk);
    if (r) model_reset();
    else begin
      if (dn_hs) m_cnt[m_sel] = (m_cnt[m_sel] + 1) % (1 << CNT_W);
      if (up_hs) begin m_full = 1; m_data = d; m_sel = sl; end
      else if (dn_hs) m_full = 0;
    end
  endtask

  typedef struct {
    logic r; logic v; logic [3:0] d; logic [1:0] s; logic [3:0] rdy;
    logic ur; logic [3:0] dv; logic [3:0] dd;
  } vec_t;

  vec_t tbl[23];
  logic        o_ur;
  logic [3:0]  o_dv, o_dd;
  logic [31:0] o_cnt;

  initial begin
    //           r  v  d     s     rdy      ur dv       dd
    tbl[0]  = '{1, 1, 4'h3, 2'd1, 4'b1111, 0, 4'b0000, 4'h0};
    tbl[1]  = '{1, 1, 4'h3, 2'd1, 4'b1111, 0, 4'b0000, 4'h0};
    tbl[2]  = '{0, 0, 4'h0, 2'd0, 4'b0000, 1, 4'b0000, 4'h0};
    tbl[3]  = '{0, 1, 4'hA, 2'd2, 4'b0100, 1, 4'b0000, 4'h0};
    tbl[4]  = '{0, 0, 4'h0, 2'd0, 4'b0100, 1, 4'b0100, 4'hA};
    tbl[5]  = '{0, 0, 4'h0, 2'd0, 4'b0000, 1, 4'b0000, 4'h0};
    tbl[6]  = '{0, 1, 4'h5, 2'd1, 4'b0000, 1, 4'b0000, 4'h0};
    tbl[7]  = '{0, 1, 4'h9, 2'd0, 4'b0000, 0, 4'b0010, 4'h5};
    tbl[8]  = '{0, 1, 4'h9, 2'd0, 4'b0001, 0, 4'b0010, 4'h5};
    tbl[9]  = '{0, 0, 4'h0, 2'd0, 4'b1000, 0, 4'b0010, 4'h5};
    tbl[10] = '{0, 0, 4'h0, 2'd0, 4'b0010, 1, 4'b0010, 4'h5};
    tbl[11] = '{0, 0, 4'h0, 2'd0, 4'b0010, 1, 4'b0000, 4'h0};
    tbl[12] = '{0, 1, 4'h1, 2'd0, 4'b1111, 1, 4'b0000, 4'h0};
    tbl[13] = '{0, 1, 4'h2, 2'd3, 4'b1111, 1, 4'b0001, 4'h1};
    tbl[14] = '{0, 1, 4'h3, 2'd3, 4'b1111, 1, 4'b1000, 4'h2};
    tbl[15] = '{0, 1, 4'h4, 2'd1, 4'b1111, 1, 4'b1000, 4'h3};
    tbl[16] = '{0, 0, 4'h0, 2'd0, 4'b1111, 1, 4'b0010, 4'h4};
    tbl[17] = '{0, 0, 4'h0, 2'd0, 4'b1111, 1, 4'b0000, 4'h0};
    tbl[18] = '{0, 1, 4'h7, 2'd3, 4'b0000, 1, 4'b0000, 4'h0};
    tbl[19] = '{0, 0, 4'h0, 2'd0, 4'b0000, 0, 4'b1000, 4'h7};
    tbl[20] = '{1, 0, 4'h0, 2'd0, 4'b0000, 0, 4'b1000, 4'h7};
    tbl[21] = '{0, 0, 4'h0, 2'd0, 4'b1111, 1, 4'b0000, 4'h0};
    tbl[22] = '{0, 0, 4'h0, 2'd0, 4'b1111, 1, 4'b0000, 4'h0};

    rst = 1; bus.up_valid = 0; bus.up_data = '0; bus.up_sel = '0; bus.dn_ready = '0;
    model_reset();

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].rdy, o_ur, o_dv, o_dd, o_cnt);
      check($sformatf("tbl%0d_up_ready", i), o_ur, tbl[i].ur);
      check($sformatf("tbl%0d_dn_valid", i), o_dv, tbl[i].dv);
      check($sformatf("tbl%0d_dn_data", i),  o_dd, tbl[i].dd);
      if (i == 5)  check("cnt_lane2_single", o_cnt[23:16], FEAT ? 8'd1 : 8'd0);
      if (i == 21) check("cnt_after_mid_rst", o_cnt, 32'h0);
    end

    // Counter wrap: 256 back-to-back transfers on lane 0.
    step(1, 0, 4'h0, 2'd0, 4'b0000, o_ur, o_dv, o_dd, o_cnt);
    for (int i = 0; i < 256; i++)
      step(0, 1, 4'(i), 2'd0, 4'b1111, o_ur, o_dv, o_dd, o_cnt);
    step(0, 0, 4'h0, 2'd0, 4'b1111, o_ur, o_dv, o_dd, o_cnt);
    step(0, 0, 4'h0, 2'd0, 4'b1111, o_ur, o_dv, o_dd, o_cnt);
    check("cnt_wrap_lane0", o_cnt[7:0], 8'd0);
    check("cnt_wrap_others", o_cnt[31:8], 24'd0);
    // One more transfer proves the counter kept running past the wrap.
    step(0, 1, 4'h6, 2'd0, 4'b1111, o_ur, o_dv, o_dd, o_cnt);
    step(0, 0, 4'h0, 2'd0, 4'b1111, o_ur, o_dv, o_dd, o_cnt);
    step(0, 0, 4'h0, 2'd0, 4'b1111, o_ur, o_dv, o_dd, o_cnt);
    check("cnt_after_wrap", o_cnt[7:0], FEAT ? 8'd1 : 8'd0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) == 0, 1'($urandom), 4'($urandom), 2'($urandom),
           4'($urandom), o_ur, o_dv, o_dd, o_cnt);

    // Bounded drain: everything accepted must come out.
    for (int i = 0; i < 8 && sb.size() != 0; i++)
      step(0, 0, 4'h0, 2'd0, 4'b1111, o_ur, o_dv, o_dd, o_cnt);
    check("drain_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
